// File: rtl/stack_sequencer.sv
// stack_sequencer: one multi-cycle FSM that handles all stack traffic for CALL, RET,
// hardware interrupt entry and RTI. It owns the stack pointer, drives the data-memory
// strobes, returns popped PC/CCR to fetch and flags, and stalls the pipeline while busy.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   call, ret, rti      instruction requests (sampled only in IDLE)
//   int_req             interrupt request pulse (latched as pending while busy)
//   pc_in, ccr_in       return address / flags to push, latched at the request edge
//   mem_rdata           memory read data, valid the cycle after mem_rd
//   mem_addr/wdata      memory address / write data
//   mem_wr, mem_rd      memory strobes
//   pc_out, pc_load     PC to load into fetch and its one-cycle strobe
//   ccr_out, ccr_load   restored flags and their one-cycle strobe
//   stall               pipeline freeze
//   sp                  current stack pointer
//   stack_err           sticky overflow/underflow flag
module stack_sequencer #(
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     MEM_W      = 16,
  parameter int unsigned     SP_W       = 16,
  parameter int unsigned     CCR_W      = 3,
  parameter logic [SP_W-1:0] SP_INIT    = SP_W'('h07FF),
  parameter logic [PC_W-1:0] INT_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             call,
  input  logic             ret,
  input  logic             rti,
  input  logic             int_req,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [CCR_W-1:0] ccr_in,
  input  logic [MEM_W-1:0] mem_rdata,
  output logic [SP_W-1:0]  mem_addr,
  output logic [MEM_W-1:0] mem_wdata,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [PC_W-1:0]  pc_out,
  output logic             pc_load,
  output logic [CCR_W-1:0] ccr_out,
  output logic             ccr_load,
  output logic             stall,
  output logic [SP_W-1:0]  sp,
  output logic             stack_err
);

  localparam int unsigned N     = (PC_W + MEM_W - 1) / MEM_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PAD_W = N * MEM_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPushPc,
    StPushCcr,
    StIntLoad,
    StPopCcr,
    StPopPc,
    StPopDone
  } state_e;

  state_e             state_q, state_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic               is_int_q, is_int_d;
  logic               is_rti_q, is_rti_d;
  // pc_q holds the PC being pushed, or collects popped words (LS word at index 0).
  logic [PAD_W-1:0]   pc_q, pc_d;
  logic [CCR_W-1:0]   ccr_q, ccr_d;
  // Remembers last cycle's read so its data can be captured when it arrives.
  logic               rd_q, rd_d;
  logic               rd_ccr_q, rd_ccr_d;
  logic [CNT_W-1:0]   rd_idx_q, rd_idx_d;

  logic [31:0]        rd_base;
  logic [31:0]        wr_base;
  logic [PAD_W-1:0]   pc_full;

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    err_d    = err_q;
    is_int_d = is_int_q;
    is_rti_d = is_rti_q;
    pc_d     = pc_q;
    ccr_d    = ccr_q;
    rd_d     = 1'b0;
    rd_ccr_d = 1'b0;
    rd_idx_d = cnt_q;

    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    pc_out    = '0;
    pc_load   = 1'b0;
    ccr_out   = '0;
    ccr_load  = 1'b0;
    stall     = (state_q != StIdle);

    rd_base = 32'(rd_idx_q) * MEM_W;
    wr_base = 32'(LAST_IDX - cnt_q) * MEM_W;

    // Final PC word is used straight from the bus in StPopDone.
    pc_full = pc_q;
    pc_full[(N-1)*MEM_W +: MEM_W] = mem_rdata;

    if (rd_q) begin
      if (rd_ccr_q) ccr_d = mem_rdata[CCR_W-1:0];
      else          pc_d[rd_base +: MEM_W] = mem_rdata;
    end

    if (int_req && (state_q != StIdle)) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pend_q || int_req) begin
          stall    = 1'b1;
          pend_d   = 1'b0;
          is_int_d = 1'b1;
          pc_d     = PAD_W'(pc_in);
          ccr_d    = ccr_in;
          state_d  = StPushPc;
        end else if (rti) begin
          stall    = 1'b1;
          is_rti_d = 1'b1;
          state_d  = StPopCcr;
        end else if (ret) begin
          stall    = 1'b1;
          is_rti_d = 1'b0;
          state_d  = StPopPc;
        end else if (call) begin
          stall    = 1'b1;
          is_int_d = 1'b0;
          pc_d     = PAD_W'(pc_in);
          state_d  = StPushPc;
        end
      end

      StPushPc: begin
        mem_wr    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = pc_q[wr_base +: MEM_W];
        sp_d      = sp_q - SP_W'(1);
        if (sp_q == '0) err_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = is_int_q ? StPushCcr : StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StPushCcr: begin
        mem_wr    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = MEM_W'(ccr_q);
        sp_d      = sp_q - SP_W'(1);
        if (sp_q == '0) err_d = 1'b1;
        state_d   = StIntLoad;
      end

      StIntLoad: begin
        pc_out  = INT_VECTOR;
        pc_load = 1'b1;
        state_d = StIdle;
      end

      StPopCcr: begin
        sp_d     = sp_q + SP_W'(1);
        mem_rd   = 1'b1;
        mem_addr = sp_q + SP_W'(1);
        if (sp_q == SP_INIT) err_d = 1'b1;
        rd_d     = 1'b1;
        rd_ccr_d = 1'b1;
        cnt_d    = '0;
        state_d  = StPopPc;
      end

      StPopPc: begin
        sp_d     = sp_q + SP_W'(1);
        mem_rd   = 1'b1;
        mem_addr = sp_q + SP_W'(1);
        if (sp_q == SP_INIT) err_d = 1'b1;
        rd_d     = 1'b1;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = StPopDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StPopDone: begin
        pc_out  = pc_full[PC_W-1:0];
        pc_load = 1'b1;
        if (is_rti_q) begin
          ccr_out  = ccr_q;
          ccr_load = 1'b1;
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Reset aborts at once: nothing reaches memory or fetch in the reset cycle.
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wr    = 1'b0;
      mem_rd    = 1'b0;
      pc_out    = '0;
      pc_load   = 1'b0;
      ccr_out   = '0;
      ccr_load  = 1'b0;
      stall     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sp_q     <= SP_INIT;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      is_int_q <= 1'b0;
      is_rti_q <= 1'b0;
      pc_q     <= '0;
      ccr_q    <= '0;
      rd_q     <= 1'b0;
      rd_ccr_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      is_int_q <= is_int_d;
      is_rti_q <= is_rti_d;
      pc_q     <= pc_d;
      ccr_q    <= ccr_d;
      rd_q     <= rd_d;
      rd_ccr_q <= rd_ccr_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  assign sp        = sp_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer (PC_W=32, MEM_W=16, SP_W=16, CCR_W=3).
// A transaction-level model turns each accepted request into the list of bus cycles
// the stack rules imply, and every DUT cycle is compared against that list.
module tb_stack_sequencer;

  localparam logic [15:0] SP_INIT = 16'h07FF;
  localparam logic [31:0] INT_VEC = 32'h0000_0100;

  logic        clk;
  logic        rst, call, ret, rti, int_req;
  logic [31:0] pc_in;
  logic [2:0]  ccr_in;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr, mem_wdata, sp;
  logic        mem_wr, mem_rd, pc_load, ccr_load, stall, stack_err;
  logic [31:0] pc_out;
  logic [2:0]  ccr_out;

  stack_sequencer #(
    .PC_W      (32),
    .MEM_W     (16),
    .SP_W      (16),
    .CCR_W     (3),
    .SP_INIT   (SP_INIT),
    .INT_VECTOR(INT_VEC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .call     (call),
    .ret      (ret),
    .rti      (rti),
    .int_req  (int_req),
    .pc_in    (pc_in),
    .ccr_in   (ccr_in),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wr   (mem_wr),
    .mem_rd   (mem_rd),
    .pc_out   (pc_out),
    .pc_load  (pc_load),
    .ccr_out  (ccr_out),
    .ccr_load (ccr_load),
    .stall    (stall),
    .sp       (sp),
    .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Bench RAM with one-cycle read latency.
  logic [15:0] ram [65536];
  bit          wrt [65536];
  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_addr] <= mem_wdata;
      wrt[mem_addr] <= 1'b1;
    end
    if (mem_rd) mem_rdata <= wrt[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        pl;
    logic [31:0] pco;
    logic        cl;
    logic [2:0]  cco;
    logic [15:0] spv;
    logic        errv;
  } cyc_t;

  cyc_t        q[$];
  logic [15:0] mdl [65536];
  logic [15:0] msp;
  logic        merr;
  logic        mpend;
  int          n_pass;
  int          n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic cyc_t base();
    cyc_t e;
    e.wr = 1'b0; e.rd = 1'b0; e.addr = '0; e.wdata = '0;
    e.pl = 1'b0; e.pco = '0; e.cl = 1'b0; e.cco = '0;
    e.spv = msp; e.errv = merr;
    return e;
  endfunction

  task automatic m_push(input logic [15:0] w);
    cyc_t e;
    e = base();
    e.wr = 1'b1; e.addr = msp; e.wdata = w;
    if (msp == 16'h0000) merr = 1'b1;
    msp = msp - 16'd1;
    q.push_back(e);
  endtask

  task automatic m_pop(output logic [15:0] d);
    cyc_t e;
    e = base();
    e.rd = 1'b1; e.addr = msp + 16'd1;
    if (msp == SP_INIT) merr = 1'b1;
    msp = msp + 16'd1;
    d = mdl[msp];
    q.push_back(e);
  endtask

  task automatic m_done(input logic [31:0] p, input logic c_en, input logic [2:0] c);
    cyc_t e;
    e = base();
    e.pl = 1'b1; e.pco = p; e.cl = c_en; e.cco = c;
    q.push_back(e);
  endtask

  task automatic eval();
    cyc_t        e;
    logic [15:0] lo, hi, cw;
    if (rst) begin
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_pc_load", 32'(pc_load), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      q.delete();
      msp = SP_INIT; merr = 1'b0; mpend = 1'b0;
    end else if (q.size() == 0) begin
      chk("idle_stall", 32'(stall), 32'(int_req | rti | ret | call | mpend));
      chk("idle_mem_wr", 32'(mem_wr), 32'd0);
      chk("idle_mem_rd", 32'(mem_rd), 32'd0);
      chk("idle_pc_load", 32'(pc_load), 32'd0);
      chk("idle_ccr_load", 32'(ccr_load), 32'd0);
      chk("idle_sp", 32'(sp), 32'(msp));
      chk("idle_stack_err", 32'(stack_err), 32'(merr));
      if (mpend || int_req) begin
        mpend = 1'b0;
        m_push(pc_in[31:16]);
        m_push(pc_in[15:0]);
        m_push({13'b0, ccr_in});
        m_done(INT_VEC, 1'b0, 3'b0);
      end else if (rti) begin
        m_pop(cw); m_pop(lo); m_pop(hi);
        m_done({hi, lo}, 1'b1, cw[2:0]);
      end else if (ret) begin
        m_pop(lo); m_pop(hi);
        m_done({hi, lo}, 1'b0, 3'b0);
      end else if (call) begin
        m_push(pc_in[31:16]);
        m_push(pc_in[15:0]);
      end
    end else begin
      e = q.pop_front();
      chk("busy_stall", 32'(stall), 32'd1);
      chk("mem_wr", 32'(mem_wr), 32'(e.wr));
      chk("mem_rd", 32'(mem_rd), 32'(e.rd));
      if (e.wr || e.rd) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      if (e.wr) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
      chk("pc_load", 32'(pc_load), 32'(e.pl));
      if (e.pl) chk("pc_out", pc_out, e.pco);
      chk("ccr_load", 32'(ccr_load), 32'(e.cl));
      if (e.cl) chk("ccr_out", 32'(ccr_out), 32'(e.cco));
      chk("busy_sp", 32'(sp), 32'(e.spv));
      chk("busy_stack_err", 32'(stack_err), 32'(e.errv));
      if (e.wr) mdl[e.addr] = e.wdata;
      if (int_req) mpend = 1'b1;
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, wait for next fall.
  task automatic cyc(input logic c, input logic r, input logic ti, input logic ir,
                     input logic rs);
    call = c; ret = r; rti = ti; int_req = ir; rst = rs;
    #1;
    eval();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; call = 1'b0; ret = 1'b0; rti = 1'b0; int_req = 1'b0;
    pc_in = '0; ccr_in = '0;
    msp = SP_INIT; merr = 1'b0; mpend = 1'b0;
    for (int a = 0; a < 65536; a++) mdl[a] = init_word(16'(a));
    @(negedge clk);

    // Reset and reset-state outputs.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("reset_pc_out", pc_out, 32'd0);
    chk("reset_ccr_out", 32'(ccr_out), 32'd0);
    chk("reset_sp", 32'(sp), 32'h07FF);

    // CALL then RET.
    pc_in = 32'h1234_5678;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("call_sp", 32'(sp), 32'h07FD);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("ret_sp", 32'(sp), 32'h07FF);

    // Interrupt entry then RTI.
    pc_in = 32'h0000_0040; ccr_in = 3'b101;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    chk("int_sp", 32'(sp), 32'h07FC);
    pc_in = '0; ccr_in = '0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);

    // int_req during the second cycle of a CALL.
    pc_in = 32'hCAFE_0010;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    pc_in = 32'h0000_0222; ccr_in = 3'b011;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(7);

    // call, ret and int_req together: only the interrupt runs.
    pc_in = 32'hABCD_EF01; ccr_in = 3'b110;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(6);

    // Underflow at SP_INIT, then reset mid-sequence.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("uflow_err", 32'(stack_err), 32'd1);
    chk("uflow_sp", 32'(sp), 32'h0801);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      pc_in  = $urandom;
      ccr_in = 3'($urandom_range(0, 7));
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 149) == 0));
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Parametrised multi-cycle sequencer for all stack traffic of CALL, RET, hardware interrupt and RTI; one FSM replaces the four separate per-instruction state machines.
- Sits between control_unit and data memory: owns the stack pointer, drives memory strobes/address/data, returns popped PC/CCR to fetch and flags, and stalls the pipeline while active.
- Generalised: PC split into any number of memory words, configurable CCR width, interrupt vector and stack base, pending-interrupt latch.

Parameters:
- PC_W, 32, program counter width
- MEM_W, 16, data memory word width; N = ceil(PC_W/MEM_W) words per PC
- SP_W, 16, stack pointer / memory address width
- CCR_W, 3, condition code width (must be <= MEM_W)
- SP_INIT, 16'h07FF, stack pointer reset value (stack grows downward)
- INT_VECTOR, 32'h0000_0000, PC loaded on interrupt entry

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- call  in  1  CALL request (one-cycle pulse)
- ret  in  1  RET request
- rti  in  1  RTI request
- int_req  in  1  interrupt request pulse
- pc_in  in  PC_W  return address to push
- ccr_in  in  CCR_W  flags to push on interrupt
- mem_rdata  in  MEM_W  memory read data, valid the cycle after mem_rd
- mem_addr  out  SP_W  memory address
- mem_wdata  out  MEM_W  memory write data
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- pc_out  out  PC_W  PC to load into fetch
- pc_load  out  1  one-cycle PC load strobe
- ccr_out  out  CCR_W  restored flags
- ccr_load  out  1  one-cycle CCR load strobe
- stall  out  1  freeze pipeline
- sp  out  SP_W  current stack pointer
- stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high. Reset sets state IDLE, sp=SP_INIT, word counter 0, pending-interrupt flag 0, stack_err 0. All strobes (mem_wr, mem_rd, pc_load, ccr_load) are 0 and mem_addr/mem_wdata/pc_out/ccr_out are 0. Reset mid-sequence aborts immediately with no further memory access.
- Stack model: push = write at sp, then sp-1 (post-decrement). Pop = sp+1, then read at the new sp (pre-increment). SP arithmetic wraps modulo 2^SP_W.
- Word order: PC is pushed most-significant word first and popped least-significant first. The top word is zero-padded if PC_W is not a multiple of MEM_W. CCR is zero-extended to MEM_W.
- IDLE selection: requests are sampled in IDLE with priority int_req > rti > ret > call. pc_in and ccr_in are latched at the request edge. stall is combinationally high in the request cycle and stays high in every non-IDLE state.
- PUSH_PC: N cycles, one write per cycle, words MS to LS. Then:
  - CALL: return to IDLE.
  - INT: go to PUSH_CCR.
- PUSH_CCR: one write, then INT_LOAD.
- INT_LOAD: pc_out=INT_VECTOR, pc_load=1 for one cycle, then IDLE.
- POP_CCR (RTI only): one read.
- POP_PC: N reads, LS word first. Data is captured one cycle after each read.
- POP_DONE: capture the last word. pc_load=1 with the assembled PC. For RTI, also ccr_load=1 with ccr_out=captured CCR[CCR_W-1:0]. Then IDLE.
- Latency from request cycle to return to IDLE (N=2):
  - CALL: 2 cycles.
  - RET: 3 cycles (2 reads + POP_DONE).
  - INT: 4 cycles (3 writes + INT_LOAD).
  - RTI: 4 cycles (3 reads + POP_DONE).
- Requests while busy: call/ret/rti are ignored (the pipeline is stalled). int_req sets the pending flag. Pending is serviced at the first IDLE cycle, ahead of any new request, and is cleared when accepted.
- stack_err (sticky until rst):
  - Overflow: set on any push while sp==0.
  - Underflow: set on any pop while sp==SP_INIT.
  - The access still proceeds with wrap.

Test Plan:
- rst, then call with pc_in=0x1234_5678, sp=0x07FF → mem_wr at 0x07FF with data 0x1234, then at 0x07FE with data 0x5678; sp=0x07FD; stall high for 2 cycles.
- ret after the previous step → mem_rd at 0x07FE then 0x07FF; pc_load=1 with pc_out=0x1234_5678; sp=0x07FF; 3 stall cycles.
- int_req with pc_in=0x0000_0040, ccr_in=3'b101 → writes 0x0000@0x07FF, 0x0040@0x07FE, 0x0005@0x07FD; then pc_load with INT_VECTOR; sp=0x07FC. rti then restores pc_out=0x0000_0040 and ccr_out=3'b101 in the same cycle.
- int_req pulsed during the 2nd cycle of a CALL → CALL completes unaltered; interrupt push begins the next cycle at sp=0x07FD.
- call and ret and int_req asserted in the same IDLE cycle → only the interrupt sequence runs; call/ret have no effect.
- ret at sp=SP_INIT → stack_err=1, reads wrap to 0x0800 and 0x0801. rst asserted mid-sequence → next cycle mem_rd=0, sp=0x07FF, stack_err=0, stall=0.
